// File: rtl/muldiv_pkg.sv
// muldiv_pkg: state enum, RV32M funct3 codes and operand-signedness helpers for the muldiv sequencer.
package muldiv_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} md_state_e;
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction
  function automatic logic is_signed_a(input logic [2:0] f);
    return f == MD_MUL || f == MD_MULH || f == MD_MULHSU || f == MD_DIV || f == MD_REM;
  endfunction
  function automatic logic is_signed_b(input logic [2:0] f);
    return f == MD_MUL || f == MD_MULH || f == MD_DIV || f == MD_REM;
  endfunction
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiply / restoring divide registers, sign fix-up and result register.
// MULDIV_FAST_MUL_EN: multiplies resolve in one step at load.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         fix_i,
  input  logic [2:0]   funct3_i,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  output logic         special_o,
  output logic [W-1:0] result_o
);
  logic [2:0]     f_q;
  logic           neg_a_q, neg_b_q;
  logic [W-1:0]   mc_q, quo_q, result_q;
  logic [2*W-1:0] prod_q;
  logic [W:0]     rem_q;
  logic           neg_a, neg_b, div_zero, ovf, neg_p;
  logic [W-1:0]   abs_a, abs_b, div_res, load_res, q_fix, r_fix, fix_res;
  logic [W:0]     sum, sh, diff;
  logic [2*W-1:0] p_fix;
  assign neg_a    = is_signed_a(funct3_i) & op_a_i[W-1];
  assign neg_b    = is_signed_b(funct3_i) & op_b_i[W-1];
  assign abs_a    = neg_a ? -op_a_i : op_a_i;
  assign abs_b    = neg_b ? -op_b_i : op_b_i;
  assign div_zero = op_b_i == '0;
  assign ovf      = is_div(funct3_i) & is_signed_a(funct3_i) & (op_a_i == {1'b1, {(W-1){1'b0}}}) & (&op_b_i);
  assign div_res  = ovf ? (funct3_i[1] ? '0 : {1'b1, {(W-1){1'b0}}}) : (funct3_i[1] ? op_a_i : '1);
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] full;
  assign full      = {{W{neg_a}}, op_a_i} * {{W{neg_b}}, op_b_i};
  assign load_res  = is_div(funct3_i) ? div_res : (funct3_i == MD_MUL ? full[W-1:0] : full[2*W-1:W]);
  assign special_o = is_div(funct3_i) ? (div_zero | ovf) : 1'b1;
`else
  assign load_res  = div_res;
  assign special_o = is_div(funct3_i) & (div_zero | ovf);
`endif
  // Multiplier sits in the low half of prod_q and shifts out as partial sums shift in.
  assign sum     = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mc_q} : '0);
  assign sh      = {rem_q[W-1:0], quo_q[W-1]};
  assign diff    = sh - {1'b0, mc_q};
  assign neg_p   = (f_q == MD_MULHSU) ? neg_a_q : neg_a_q ^ neg_b_q;
  assign p_fix   = neg_p ? -prod_q : prod_q;
  assign q_fix   = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
  assign r_fix   = neg_a_q ? -rem_q[W-1:0] : rem_q[W-1:0];
  assign fix_res = !f_q[2] ? (f_q == MD_MUL ? p_fix[W-1:0] : p_fix[2*W-1:W]) : (f_q[1] ? r_fix : q_fix);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f_q      <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mc_q     <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else begin
      if (load_i) begin
        f_q     <= funct3_i;
        neg_a_q <= neg_a;
        neg_b_q <= neg_b;
        mc_q    <= is_div(funct3_i) ? abs_b : abs_a;
        prod_q  <= {{W{1'b0}}, abs_b};
        rem_q   <= '0;
        quo_q   <= abs_a;
        if (special_o) result_q <= load_res;
      end else if (step_i) begin
        prod_q <= {sum, prod_q[W-1:1]};
        rem_q  <= diff[W] ? sh : diff;
        quo_q  <= {quo_q[W-2:0], ~diff[W]};
      end
      if (fix_i) result_q <= fix_res;
    end
  end
  assign result_o = result_q;
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: RV32M multiply/divide controller (FSM, iteration counter, start/flush handshake).
// MULDIV_FAST_MUL_EN: single-step multiplies (handled in muldiv_datapath).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int CW = $clog2(DATA_WIDTH);
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, special;
  assign accept = start_i & ~flush_i & (state_q == S_IDLE || state_q == S_DONE);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) state_d = S_IDLE;
    else if (accept) begin
      state_d = special ? S_DONE : S_CALC;
      cnt_d   = CW'(DATA_WIDTH - 1);
    end else if (state_q == S_CALC) begin
      state_d = cnt_q == '0 ? S_FIX : S_CALC;
      cnt_d   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
    end else if (state_q == S_FIX) state_d = S_DONE;
    else if (state_q == S_DONE) state_d = S_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy_o = state_q == S_CALC || state_q == S_FIX;
  assign done_o = state_q == S_DONE;
  // A flush during FIX must not commit the result.
  muldiv_datapath #(.W(DATA_WIDTH)) u_dp (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (accept),
    .step_i    (state_q == S_CALC),
    .fix_i     (state_q == S_FIX && !flush_i),
    .funct3_i  (funct3_i),
    .op_a_i    (op_a_i),
    .op_b_i    (op_b_i),
    .special_o (special),
    .result_o  (result_o)
  );
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer (default build, iterative multiplies).
module tb_muldiv_sequencer;
  import muldiv_pkg::*;
  logic        clk = 0, rst = 1, start = 0, flush = 0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done;
  logic [31:0] result;
  int n_vec = 0, n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush), .funct3_i(funct3),
    .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy), .done_o(done), .result_o(result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (done) begin
      if (exp_q.size() == 0) check("spurious_done", {31'b0, done}, 32'd0);
      else check(tag_q.pop_front(), result, exp_q.pop_front());
    end
  task automatic do_op(input bit now, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag, input int ign_at);
    int cyc, busy_n;
    if (!now) @(negedge clk);
    start = 1; funct3 = f; op_a = a; op_b = b;
    exp_q.push_back(exp); tag_q.push_back(tag);
    @(negedge clk);
    start = 0;
    cyc = 1; busy_n = 0;
    while (!done && cyc < 100) begin
      busy_n += int'(busy);
      start = (cyc == ign_at);
      if (start) begin funct3 = MD_MUL; op_a = 3; op_b = 3; end
      @(negedge clk);
      cyc++;
    end
    start = 0;
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_busy"}, busy_n, lat - 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_result", result, 0);
    rst = 0;
    do_op(0, MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul",    0);
    do_op(0, MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh",   0);
    do_op(0, MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu",  0);
    do_op(0, MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, "mulhsu", 0);
    do_op(0, MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div",    0);
    do_op(0, MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem",    0);
    do_op(0, MD_DIVU,   32'd100,      32'd7,        32'd14,       34, "divu",   0);
    do_op(0, MD_REMU,   32'd100,      32'd7,        32'd2,        34, "remu",   0);
    repeat (5) @(negedge clk);
    check("hold_result", result, 32'd2);
    do_op(0, MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1, "divu_z",  0);
    do_op(0, MD_REM,    32'd5,        32'd0,        32'd5,        1, "rem_z",   0);
    do_op(0, MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf", 0);
    do_op(0, MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "rem_ovf", 0);
    do_op(0, MD_REMU,   32'd100,      32'd7,        32'd2,        34, "remu2",  0);
    @(negedge clk);
    start = 1; funct3 = MD_DIV; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    flush = 1; start = 1;
    @(negedge clk);
    flush = 0; start = 0;
    check("flush_busy", {31'b0, busy}, 0);
    check("flush_done", {31'b0, done}, 0);
    check("flush_result", result, 32'd2);
    repeat (40) @(negedge clk);
    check("flush_hold", result, 32'd2);
    do_op(0, MD_DIVU, 32'd100, 32'd7, 32'd14, 34, "ign_start", 5);
    repeat (40) @(negedge clk);
    @(negedge clk);
    start = 1; funct3 = MD_MUL; op_a = 32'd7; op_b = 32'd3;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_mid_busy", {31'b0, busy}, 0);
    check("rst_mid_done", {31'b0, done}, 0);
    check("rst_mid_result", result, 0);
    rst = 0;
    repeat (40) @(negedge clk);
    do_op(0, MD_MUL,  32'd7,   32'hFFFFFFFD, 32'hFFFFFFEB, 34, "b2b_1", 0);
    do_op(1, MD_DIVU, 32'd100, 32'd7,        32'd14,       34, "b2b_2", 0);
    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
